ram_access_ctrl: RTL and testbench
==================================

Name: ram_access_ctrl

Overview:
- Controller placed in front of the dual-port `ram` block, with:
  - read/write port A (one-cycle registered read);
  - read-only port B.
- Port A is shared between two requesters by a round-robin arbiter.
- Port B is driven by a sequencer that streams a contiguous address range out through a valid/ready interface with backpressure.
- The block owns all RAM address and control pins; nothing else drives the RAM.

Parameters:
- ADDR_SIZE, 4, RAM address width (depth 2**ADDR_SIZE)
- DATA_SIZE, 32, RAM word width

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high reset
- req0 / req1  in  1  requester i wants a port-A access this cycle
- we0 / we1  in  1  requester i access is a write
- addr0 / addr1  in  ADDR_SIZE  requester i address
- wdata0 / wdata1  in  DATA_SIZE  requester i write data
- gnt0 / gnt1  out  1  access of requester i issued this cycle
- rvalid0 / rvalid1  out  1  read data for requester i valid
- rdata0 / rdata1  out  DATA_SIZE  read data for requester i
- ram_addr_A  out  ADDR_SIZE  to RAM addr_A
- ram_data_in_A  out  DATA_SIZE  to RAM data_in_A
- ram_w_e_A  out  1  to RAM w_e_A
- ram_data_out_A  in  DATA_SIZE  from RAM data_out_A
- ram_addr_B  out  ADDR_SIZE  to RAM addr_B
- ram_data_out_B  in  DATA_SIZE  from RAM data_out_B
- rd_start  in  1  start-stream pulse
- rd_base  in  ADDR_SIZE  first stream address
- rd_len  in  ADDR_SIZE+1  word count, 0..2**ADDR_SIZE
- rd_busy  out  1  stream in progress
- rd_done  out  1  one-cycle completion pulse
- st_valid  out  1  stream word available
- st_data  out  DATA_SIZE  stream word
- st_ready  in  1  consumer accepts word

Behaviour:

Reset:
- All outputs 0.
- Priority pointer favours requester 0.
- Stream FSM in IDLE, FIFO empty, no read in flight.
- Reset mid-operation aborts any stream and drops in-flight port-A reads: no rvalid, no rd_done.

Port A arbiter:
- Grant is combinational from req0/req1 and the priority pointer.
- At most one gnt per cycle.
- Single requester: granted immediately.
- Both requesting: the prioritised requester wins.
- After a grant to requester i, priority moves to the other requester.
- No request: pointer unchanged.
- In the grant cycle, ram_addr_A/ram_data_in_A/ram_w_e_A carry the granted requester's addr/wdata/we. The RAM samples them at the next edge.
- Idle cycle: ram_w_e_A=0, ram_addr_A=0, ram_data_in_A=0.
- Granted read at cycle t: rvalid_i=1 at cycle t+1 for exactly one cycle, and rdata_i = ram_data_out_A. rdata_i is don't-care otherwise.
- Granted write: no rvalid. The stale read-before-write data the RAM returns is discarded.
- A requester not granted keeps its request asserted; the arbiter stores nothing.
- Throughput is one access per cycle; back-to-back grants are allowed.

Stream sequencer, states IDLE, RUN, DRAIN:
- IDLE:
  - rd_start with rd_len>0: latch base/len, go to RUN; rd_busy=1 from the next cycle.
  - rd_start with rd_len=0: rd_done=1 next cycle, no data, stay IDLE.
- rd_start outside IDLE is ignored.
- RUN:
  - Issue one read per cycle on ram_addr_B while (FIFO count + in-flight) < 2 and words remain to issue.
  - Address increments modulo 2**ADDR_SIZE, so it wraps from max to 0.
  - The read data is captured into the 2-entry FIFO the cycle after issue, tracked by an in-flight flag.
  - When the last address has been issued, go to DRAIN.
- DRAIN:
  - Wait until every word has been accepted.
  - In the cycle after the final accept: rd_done=1 and rd_busy=0, then return to IDLE.
- Handshake:
  - st_valid = FIFO non-empty; st_data = FIFO head.
  - Transfer when st_valid && st_ready.
  - st_data is stable while st_valid && !st_ready.
- Capture and accept in the same cycle are legal; the count stays unchanged.
- ram_addr_B holds its last value when not issuing.
- With st_ready held at 1, sustained rate is one word per cycle after 2 cycles of startup latency.
- Port A and port B operate independently. A port-A write to an address the stream reads in the same cycle returns old data (RAM read-before-write).

Test Plan:
1. req0 only, write addr 3 = 0xA5A5A5A5, then read addr 3 → gnt0 both cycles; rvalid0 on cycle after read grant with rdata0=0xA5A5A5A5; no rvalid0 for the write.
2. req0 and req1 both held for 4 cycles (reads) → grants alternate 0,1,0,1; each rvalid one cycle after its grant; never two gnts in one cycle.
3. Preload RAM[i]=i; stream rd_base=14, rd_len=5, st_ready=1 → st_data 14,15,0,1,2 on consecutive cycles; rd_done one cycle after word 2; rd_busy drops the same cycle.
4. Same stream with st_ready toggling 1,0,0,1,… → no word lost or duplicated; st_data stable while stalled; FIFO never exceeds 2.
5. rd_len=0 → rd_done next cycle, st_valid never asserted; rd_start during RUN → ignored, stream completes unchanged.
6. reset asserted mid-stream after 2 words accepted → all outputs 0 next cycle, no rd_done; a fresh stream after reset works from its rd_base.

Source files
------------

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: round-robin port-A arbiter and port-B streaming read sequencer for a dual-port RAM
module ram_access_ctrl #(
    parameter int ADDR_SIZE = 4,
    parameter int DATA_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0,
    input  logic                 req1,
    input  logic                 we0,
    input  logic                 we1,
    input  logic [ADDR_SIZE-1:0] addr0,
    input  logic [ADDR_SIZE-1:0] addr1,
    input  logic [DATA_SIZE-1:0] wdata0,
    input  logic [DATA_SIZE-1:0] wdata1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic                 rvalid0,
    output logic                 rvalid1,
    output logic [DATA_SIZE-1:0] rdata0,
    output logic [DATA_SIZE-1:0] rdata1,
    output logic [ADDR_SIZE-1:0] ram_addr_A,
    output logic [DATA_SIZE-1:0] ram_data_in_A,
    output logic                 ram_w_e_A,
    input  logic [DATA_SIZE-1:0] ram_data_out_A,
    output logic [ADDR_SIZE-1:0] ram_addr_B,
    input  logic [DATA_SIZE-1:0] ram_data_out_B,
    input  logic                 rd_start,
    input  logic [ADDR_SIZE-1:0] rd_base,
    input  logic [ADDR_SIZE:0]   rd_len,
    output logic                 rd_busy,
    output logic                 rd_done,
    output logic                 st_valid,
    output logic [DATA_SIZE-1:0] st_data,
    input  logic                 st_ready
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t                 state, state_nxt;
    logic                   prio;
    logic                   pend0, pend1;
    logic [ADDR_SIZE:0]     rem;
    logic [ADDR_SIZE-1:0]   nxt_addr, last_addr;
    logic                   inflight;
    logic [DATA_SIZE-1:0]   fifo [2];
    logic                   wp, rp;
    logic [1:0]             cnt;
    logic                   done;
    logic                   issue, accept, last_accept;

    assign gnt0     = !reset && req0 && (!req1 || !prio);
    assign gnt1     = !reset && req1 && (!req0 || prio);
    assign rvalid0  = pend0;
    assign rvalid1  = pend1;
    assign rdata0   = pend0 ? ram_data_out_A : '0;
    assign rdata1   = pend1 ? ram_data_out_A : '0;
    assign st_valid = cnt != 2'd0;
    assign st_data  = fifo[rp];
    assign rd_busy  = state != IDLE;
    assign rd_done  = done;
    assign accept   = st_valid && st_ready;
    // the slot freed by this cycle's accept is counted so a held-ready consumer gets one word per cycle
    assign issue       = !reset && state == RUN && (cnt + 2'(inflight) - 2'(accept)) < 2'd2;
    assign last_accept = state == DRAIN && !inflight && cnt == 2'd1 && accept;
    assign ram_addr_B  = issue ? nxt_addr : last_addr;

    // port-A pins follow the granted requester, zero when idle
    always_comb begin
        ram_w_e_A     = gnt0 ? we0 : gnt1 && we1;
        ram_addr_A    = gnt0 ? addr0 : gnt1 ? addr1 : '0;
        ram_data_in_A = gnt0 ? wdata0 : gnt1 ? wdata1 : '0;
    end

    // round-robin pointer and one-cycle read-return tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            prio  <= 1'b0;
            pend0 <= 1'b0;
            pend1 <= 1'b0;
        end else begin
            prio  <= gnt0 ? 1'b1 : gnt1 ? 1'b0 : prio;
            pend0 <= gnt0 && !we0;
            pend1 <= gnt1 && !we1;
        end
    end

    // stream FSM next-state
    always_comb begin
        state_nxt = state;
        if (state == IDLE && rd_start && rd_len != '0)
            state_nxt = RUN;
        if (issue && rem == (ADDR_SIZE+1)'(1))
            state_nxt = DRAIN;
        if (last_accept)
            state_nxt = IDLE;
    end

    // stream FSM state register
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // stream address/count, in-flight tracking, 2-entry FIFO and done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            rem       <= '0;
            nxt_addr  <= '0;
            last_addr <= '0;
            inflight  <= 1'b0;
            fifo[0]   <= '0;
            fifo[1]   <= '0;
            wp        <= 1'b0;
            rp        <= 1'b0;
            cnt       <= 2'd0;
            done      <= 1'b0;
        end else begin
            if (state == IDLE && rd_start) begin
                nxt_addr <= rd_base;
                rem      <= rd_len;
            end else if (issue) begin
                nxt_addr <= nxt_addr + ADDR_SIZE'(1);
                rem      <= rem - (ADDR_SIZE+1)'(1);
            end
            if (issue)
                last_addr <= nxt_addr;
            inflight <= issue;
            if (inflight) begin
                fifo[wp] <= ram_data_out_B;
                wp       <= ~wp;
            end
            if (accept)
                rp <= ~rp;
            cnt  <= cnt + 2'(inflight) - 2'(accept);
            done <= (state == IDLE && rd_start && rd_len == '0) || last_accept;
        end
    end
endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb_ram_access_ctrl: randomized scoreboard bench for ram_access_ctrl with a behavioural RAM
module tb_ram_access_ctrl;
    localparam int AW = 4;
    localparam int DW = 32;

    logic          clk = 0, reset = 1;
    logic          req0 = 0, req1 = 0, we0 = 0, we1 = 0;
    logic [AW-1:0] addr0 = 0, addr1 = 0;
    logic [DW-1:0] wdata0 = 0, wdata1 = 0;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] ram_addr_A, ram_addr_B;
    logic [DW-1:0] ram_data_in_A, ram_data_out_A, ram_data_out_B;
    logic          ram_w_e_A;
    logic          rd_start = 0;
    logic [AW-1:0] rd_base = 0;
    logic [AW:0]   rd_len = 0;
    logic          rd_busy, rd_done, st_valid, st_ready = 0;
    logic [DW-1:0] st_data;

    always #5 clk = ~clk;

    ram_access_ctrl #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .ram_addr_A(ram_addr_A), .ram_data_in_A(ram_data_in_A), .ram_w_e_A(ram_w_e_A),
        .ram_data_out_A(ram_data_out_A), .ram_addr_B(ram_addr_B), .ram_data_out_B(ram_data_out_B),
        .rd_start(rd_start), .rd_base(rd_base), .rd_len(rd_len),
        .rd_busy(rd_busy), .rd_done(rd_done),
        .st_valid(st_valid), .st_data(st_data), .st_ready(st_ready)
    );

    // behavioural dual-port RAM: registered reads, read-before-write on port A
    logic [DW-1:0] mem [16];
    always @(posedge clk) begin
        if (ram_w_e_A) mem[ram_addr_A] <= ram_data_in_A;
        ram_data_out_A <= mem[ram_addr_A];
        ram_data_out_B <= mem[ram_addr_B];
    end

    // reference model state and scoreboards
    typedef struct {int id; int due; logic [DW-1:0] d;} rd_t;
    rd_t           aq[$];
    logic [DW-1:0] sq[$];
    logic [DW-1:0] ref_mem [16];
    int            errors = 0, checks = 0, cyc = 0;
    bit            m_prio = 0, m_busy = 0, m_done = 0, stall_prev = 0, full_rate = 0;
    logic [DW-1:0] stall_data;
    int            nacc = 0, last_acc = 0;
    bit            e0, e1, exp_rv, old_busy, nd, acc;

    initial for (int i = 0; i < 16; i++) begin mem[i] = 0; ref_mem[i] = 0; end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // monitor: compares DUT outputs against the model each cycle, away from the clock edge
    always @(negedge clk) begin
        if (reset) begin
            chk("reset_gnt", {gnt0, gnt1}, 0);
            aq.delete(); sq.delete();
            m_prio = 0; m_busy = 0; m_done = 0; stall_prev = 0;
        end else begin
            e0 = req0 && (!req1 || !m_prio);
            e1 = req1 && !e0;
            chk("gnt0", gnt0, e0);
            chk("gnt1", gnt1, e1);
            chk("ram_w_e_A", ram_w_e_A, e0 ? we0 : (e1 && we1));
            chk("ram_addr_A", ram_addr_A, e0 ? addr0 : e1 ? addr1 : 0);
            chk("ram_data_in_A", ram_data_in_A, e0 ? wdata0 : e1 ? wdata1 : 0);
            exp_rv = aq.size() != 0 && aq[0].due == cyc;
            chk("rvalid0", rvalid0, exp_rv && aq[0].id == 0);
            chk("rvalid1", rvalid1, exp_rv && aq[0].id == 1);
            if (exp_rv) begin
                chk("rdata", aq[0].id == 1 ? rdata1 : rdata0, aq[0].d);
                void'(aq.pop_front());
            end
            if (e0 || e1) begin
                if (e0 ? we0 : we1)
                    ref_mem[e0 ? addr0 : addr1] = e0 ? wdata0 : wdata1;
                else
                    aq.push_back('{id: e0 ? 0 : 1, due: cyc + 1, d: ref_mem[e0 ? addr0 : addr1]});
                m_prio = e0;
            end
            old_busy = m_busy; nd = 0; acc = st_valid && st_ready;
            chk("rd_busy", rd_busy, m_busy);
            chk("rd_done", rd_done, m_done);
            if (!m_busy) chk("st_valid_idle", st_valid, 0);
            if (stall_prev) begin
                chk("stall_valid", st_valid, 1);
                chk("stall_data", st_data, stall_data);
            end
            if (acc) begin
                if (sq.size() == 0) chk("st_unexpected", acc, 0);
                else begin
                    chk("st_data", st_data, sq.pop_front());
                    nacc++;
                    if (full_rate && nacc > 1) chk("st_rate", cyc, last_acc + 1);
                    last_acc = cyc;
                    if (sq.size() == 0) begin m_busy = 0; nd = 1; end
                end
            end
            stall_prev = st_valid && !st_ready;
            stall_data = st_data;
            if (!old_busy && rd_start) begin
                if (rd_len == 0) nd = 1;
                else begin
                    m_busy = 1; nacc = 0;
                    for (int k = 0; k < int'(rd_len); k++) sq.push_back(ref_mem[4'(int'(rd_base) + k)]);
                end
            end
            m_done = nd;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle_a();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    endtask

    task automatic rand_a(bit allow_w);
        req0 = 1'($urandom_range(1)); req1 = 1'($urandom_range(1));
        we0 = allow_w && 1'($urandom_range(1)); we1 = allow_w && 1'($urandom_range(1));
        addr0 = 4'($urandom_range(15)); addr1 = 4'($urandom_range(15));
        wdata0 = $urandom; wdata1 = $urandom;
    endtask

    task automatic start_stream(int b, int l);
        rd_start = 1; rd_base = 4'(b); rd_len = 5'(l);
        tick();
        rd_start = 0;
    endtask

    // mode 0: ready held, 1: ready 1,0,0 repeating, 2: random ready
    task automatic run_stream(int mode, bit port_a);
        for (int k = 0; k < 400; k++) begin
            if (!(m_busy || m_done || sq.size() != 0)) break;
            st_ready = mode == 0 ? 1'b1 : mode == 1 ? (k % 3 == 0) : ($urandom_range(2) != 0);
            if (port_a) rand_a(0);
            tick();
        end
        idle_a();
        chk("stream_finished", m_busy, 0);
    endtask

    task automatic check_outputs_zero(string nm);
        chk(nm, {gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, ram_addr_A, ram_data_in_A, ram_w_e_A,
                 ram_addr_B, rd_busy, rd_done, st_valid, st_data}, 0);
    endtask

    initial begin
        repeat (3) tick();
        reset = 0;
        @(negedge clk);
        check_outputs_zero("reset_outputs");
        tick();
        // both requesters reading for four cycles: alternating grants from requester 0
        req0 = 1; req1 = 1; addr0 = 3; addr1 = 7;
        repeat (4) tick();
        idle_a(); tick();
        // requester 0 write then read of address 3
        req0 = 1; we0 = 1; addr0 = 3; wdata0 = 32'hA5A5A5A5; tick();
        we0 = 0; tick();
        idle_a(); repeat (2) tick();
        // random port-A traffic
        for (int i = 0; i < 300; i++) begin rand_a(1); tick(); end
        idle_a(); tick();
        // preload RAM[i] = i
        for (int i = 0; i < 16; i++) begin req0 = 1; we0 = 1; addr0 = 4'(i); wdata0 = i; tick(); end
        idle_a(); tick();
        // wrapping stream at full rate
        full_rate = 1; st_ready = 1;
        start_stream(14, 5); run_stream(0, 0);
        full_rate = 0;
        // same stream with stalls
        start_stream(14, 5); run_stream(1, 0);
        // zero-length stream
        start_stream(6, 0); run_stream(0, 0);
        // start during RUN is ignored
        st_ready = 1;
        start_stream(2, 6); tick();
        rd_start = 1; rd_base = 0; rd_len = 3; tick();
        rd_start = 0; run_stream(0, 0);
        // full-depth stream with port-A reads alongside
        start_stream(9, 16); run_stream(2, 1);
        // random streams
        for (int i = 0; i < 8; i++) begin
            start_stream($urandom_range(15), $urandom_range(16, 1)); run_stream(2, 1);
        end
        // reset mid-stream after two accepted words
        st_ready = 1;
        start_stream(5, 10);
        for (int k = 0; k < 50 && nacc < 2; k++) tick();
        reset = 1; tick(); reset = 0;
        @(negedge clk);
        check_outputs_zero("midreset_outputs");
        tick();
        start_stream(9, 4); run_stream(0, 0);
        repeat (3) tick();
        chk("read_queue_empty", aq.size(), 0);
        chk("stream_queue_empty", sq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
